// File: rtl/mem_req_ctrl_pkg.sv
// Shared types for the register-file request front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/mem_req_ctrl_if.sv
// Client-side request/response channel of mem_req_ctrl.
// Latency: n/a (wiring only).
// Backpressure: req_ready from the controller, rsp_ready from the client.
interface mem_req_ctrl_if;
    import mem_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;

    // Client side
    modport master (
        output req_valid, req_wr, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

    // Controller side
    modport slave (
        input  req_valid, req_wr, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err
    );

endinterface

// File: rtl/mem_req_ctrl_fifo.sv
// Synchronous FIFO of mem_req_t requests.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
module mem_req_fifo
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     push,
    input  mem_req_t push_dat,
    input  logic     pop,
    output mem_req_t head_dat,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    mem_req_t    mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem_q[rptr_q[AW-1:0]];

    // Pointer update; reset empties the FIFO.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Sequences buffered client read/write requests onto a 16x32 register-file memory.
// Latency: push in cycle 0 -> mem_en in cycle 2; read response held from cycle 4.
// Backpressure: req_ready = !fifo_full; a read head stalls while a response is held.
// Optional read timeout in WAIT enabled by macro MEM_REQ_CTRL_TIMEOUT_EN.
module mem_req_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 8
) (
    input  logic              CLK,
    input  logic              RST,
    mem_req_ctrl_if.slave     req_if,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_w_r,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_req_ctrl: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
    end

    ctrl_state_e       state_q;
    logic              mem_en_q;
    logic              mem_w_r_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [ADDR_W-1:0] rsp_addr_q;

    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     fifo_pop;
    mem_req_t head_dat;
    mem_req_t push_dat;

    assign push_dat  = '{wr: req_if.req_wr, addr: req_if.req_addr, data: req_if.req_data};
    assign fifo_push = req_if.req_valid && !fifo_full;
    // Writes never touch the response register, so only a read head waits for it to drain.
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty && (head_dat.wr || !rsp_valid_q);

    mem_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (fifo_push),
        .push_dat (push_dat),
        .pop      (fifo_pop),
        .head_dat (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          rsp_err_q;
`endif

    // Request sequencer: issue pulse, memory-side output registers and held response.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_w_r_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_addr_q  <= '0;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            if (rsp_valid_q && req_if.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (fifo_pop) begin
                        mem_en_q    <= 1'b1;
                        mem_w_r_q   <= head_dat.wr;
                        mem_addr_q  <= head_dat.addr;
                        mem_wdata_q <= head_dat.data;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Memory samples its pins at the end of this cycle.
                    mem_en_q <= 1'b0;
                    state_q  <= mem_w_r_q ? IDLE : WAIT;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                WAIT: begin
                    if (mem_valid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= mem_rdata;
                        rsp_addr_q  <= mem_addr_q;
                        state_q     <= IDLE;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= '0;
                        rsp_addr_q  <= mem_addr_q;
                        rsp_err_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tmo_cnt_q   <= tmo_cnt_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_if.req_ready = !fifo_full;
    assign req_if.rsp_valid = rsp_valid_q;
    assign req_if.rsp_data  = rsp_data_q;
    assign req_if.rsp_addr  = rsp_addr_q;
`ifdef MEM_REQ_CTRL_TIMEOUT_EN
    assign req_if.rsp_err   = rsp_err_q;
`else
    assign req_if.rsp_err   = 1'b0;
`endif

    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign mem_en    = mem_en_q;
    assign mem_w_r   = mem_w_r_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl with a behavioural 16x32 register-file memory.
// Latency: n/a.
// Backpressure: memory response can be stalled; rsp_ready driven per test.
module tb_mem_req_ctrl;
    import mem_ctrl_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              err;
    } exp_t;

    logic              CLK;
    logic              RST;
    logic              busy;
    logic              mem_en;
    logic              mem_w_r;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    mem_req_ctrl_if bus();

    mem_req_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_if    (bus),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_w_r   (mem_w_r),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    exp_t              exp_wr[$];
    exp_t              exp_rsp[$];
    logic [ADDR_W-1:0] exp_rd[$];
    int                en_log[$];
    int                rise_log[$];
    int                rd_issue_cnt = 0;
    logic [DATA_W-1:0] last_rsp_data = '0;
    logic              rsp_prev = 1'b0;
    logic [DATA_W-1:0] ref_mem [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural register file; mem_stall defers Valid_Out of a read.
    logic [DATA_W-1:0] tmem [16];
    logic              mem_stall = 1'b0;
    logic              pend;
    logic [DATA_W-1:0] pdata;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) tmem[i] <= '0;
            mem_valid <= 1'b0;
            mem_rdata <= '0;
            pend      <= 1'b0;
            pdata     <= '0;
        end else begin
            mem_valid <= 1'b0;
            if (mem_en && mem_w_r) tmem[mem_addr] <= mem_wdata;
            if (mem_en && !mem_w_r) begin
                if (!mem_stall) begin
                    mem_valid <= 1'b1;
                    mem_rdata <= tmem[mem_addr];
                end else begin
                    pend  <= 1'b1;
                    pdata <= tmem[mem_addr];
                end
            end else if (pend && !mem_stall) begin
                mem_valid <= 1'b1;
                mem_rdata <= pdata;
                pend      <= 1'b0;
            end
        end
    end

    // Monitor: memory-side issues and response handshakes against the scoreboard.
    always @(negedge CLK) begin
        if (RST) begin
            if (mem_en) begin
                en_log.push_back(cyc);
                if (mem_w_r) begin
                    if (exp_wr.size() == 0) chk("wr_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                    else begin
                        exp_t e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                        chk("wr_data", mem_wdata, e.data);
                    end
                end else begin
                    rd_issue_cnt++;
                    if (exp_rd.size() == 0) chk("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                    else chk("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
                end
            end
            if (bus.rsp_valid && !rsp_prev) rise_log.push_back(cyc);
            if (bus.rsp_valid && bus.rsp_ready) begin
                last_rsp_data = bus.rsp_data;
                if (exp_rsp.size() == 0) chk("rsp_unexpected", bus.rsp_data, 32'hFFFF_FFFF);
                else begin
                    exp_t e;
                    e = exp_rsp.pop_front();
                    chk("rsp_data", bus.rsp_data, e.data);
                    chk("rsp_addr", 32'(bus.rsp_addr), 32'(e.addr));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
            rsp_prev = bus.rsp_valid;
        end else begin
            rsp_prev = 1'b0;
        end
    end

    task automatic flush_sb();
        exp_wr.delete();
        exp_rsp.delete();
        exp_rd.delete();
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    endtask

    task automatic book(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        exp_t e;
        e.addr = a;
        e.err  = 1'b0;
        if (wr) begin
            ref_mem[a] = d;
            e.data = d;
            exp_wr.push_back(e);
        end else begin
            e.data = ref_mem[a];
            exp_rd.push_back(a);
            exp_rsp.push_back(e);
        end
    endtask

    // Entered just after a rising edge; leaves just after the accepting edge.
    task automatic send(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = a;
        bus.req_data  = d;
        n = 0;
        @(negedge CLK);
        while (!bus.req_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.req_ready) chk("push_timeout", 32'(bus.req_ready), 32'd1);
        else book(wr, a, d);
        @(posedge CLK);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        @(negedge CLK);
        while ((busy || bus.rsp_valid || exp_wr.size() != 0 || exp_rsp.size() != 0) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, 32'(busy || bus.rsp_valid), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        flush_sb();
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n_en;
        RST           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;

        do_reset();
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);

        // 1: write then read the same address; check issue and response cycles.
        en_log.delete();
        rise_log.delete();
        t0 = cyc;
        send(1'b1, 4'd3, 32'hDEAD_BEEF);
        send(1'b0, 4'd3, 32'h0);
        wait_drain("t1_drain");
        chk("t1_en_count", 32'(en_log.size()), 32'd2);
        if (en_log.size() >= 2) begin
            chk("t1_en_first_cyc", 32'(en_log[0] - t0), 32'd2);
            chk("t1_en_second_cyc", 32'(en_log[1] - t0), 32'd4);
        end
        if (rise_log.size() >= 1) chk("t1_rsp_cyc", 32'(rise_log[0] - t0), 32'd6);
        chk("t1_rsp_seen", 32'(rise_log.size()), 32'd1);
        chk("t1_last_data", last_rsp_data, 32'hDEAD_BEEF);

        // 2: a stalled read keeps the FSM in WAIT; 5 writes fill the FIFO after 4.
        mem_stall = 1'b1;
        send(1'b0, 4'd5, 32'h0);
        for (int i = 0; i < 4; i++) send(1'b1, 4'(8 + i), 32'hA000_0000 + 32'(i));
        @(negedge CLK);
        chk("t2_full_ready", 32'(bus.req_ready), 32'd0);
        chk("t2_busy", 32'(busy), 32'd1);
        @(posedge CLK);
        #1;
        fork
            send(1'b1, 4'd12, 32'hA000_0004);
            begin
                repeat (4) @(posedge CLK);
                chk("t2_held_back", 32'(exp_wr.size()), 32'd4);
                #1;
                mem_stall = 1'b0;
            end
        join
        wait_drain("t2_drain");

        // 3: two reads with the response held; second issue waits for the consume.
        bus.rsp_ready = 1'b0;
        send(1'b1, 4'd1, 32'h1111_1111);
        send(1'b1, 4'd2, 32'h2222_2222);
        wait_drain("t3_wr_drain");
        rd_issue_cnt = 0;
        send(1'b0, 4'd1, 32'h0);
        send(1'b0, 4'd2, 32'h0);
        repeat (12) @(negedge CLK);
        chk("t3_one_issue", 32'(rd_issue_cnt), 32'd1);
        chk("t3_rsp_held", 32'(bus.rsp_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("t3_rsp_stable", bus.rsp_data, 32'h1111_1111);
        end
        chk("t3_rsp_addr", 32'(bus.rsp_addr), 32'd1);
        @(posedge CLK);
        #1;
        bus.rsp_ready = 1'b1;
        wait_drain("t3_drain");
        chk("t3_two_issues", 32'(rd_issue_cnt), 32'd2);

        // 4: reset while a read sits in WAIT with three more queued.
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, 4'(1 + i), 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("t4_pre_busy", 32'(busy), 32'd1);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        chk("t4_mem_en", 32'(mem_en), 32'd0);
        chk("t4_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t4_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        flush_sb();
        mem_stall = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        n_en = en_log.size();
        repeat (6) @(negedge CLK);
        chk("t4_no_issue", 32'(en_log.size()), 32'(n_en));
        chk("t4_idle", 32'(busy), 32'd0);
        @(posedge CLK);
        #1;

        // 5: read of address 0 straight after reset.
        send(1'b0, 4'd0, 32'h0);
        wait_drain("t5_drain");
        chk("t5_data", last_rsp_data, 32'h0);

`ifdef MEM_REQ_CTRL_TIMEOUT_EN
        // 6: memory never answers; the read times out after 8 WAIT cycles.
        begin
            exp_t e;
            int n;
            mem_stall = 1'b1;
            bus.rsp_ready = 1'b0;
            rise_log.delete();
            t0 = cyc;
            send(1'b0, 4'd9, 32'h0);
            e.addr = 4'd9;
            e.data = '0;
            e.err  = 1'b1;
            void'(exp_rsp.pop_back());
            exp_rsp.push_back(e);
            n = 0;
            @(negedge CLK);
            while (!bus.rsp_valid && n < 50) begin
                @(negedge CLK);
                n++;
            end
            chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("t6_rsp_err", 32'(bus.rsp_err), 32'd1);
            chk("t6_rsp_data", bus.rsp_data, 32'd0);
            chk("t6_fsm_idle", 32'(busy), 32'd0);
            if (rise_log.size() >= 1) chk("t6_rsp_cyc", 32'(rise_log[0] - t0), 32'd11);
            @(posedge CLK);
            #1;
            bus.rsp_ready = 1'b1;
            wait_drain("t6_drain");
            mem_stall = 1'b0;
            do_reset();
        end
`endif

        chk("sb_wr_empty", 32'(exp_wr.size()), 32'd0);
        chk("sb_rsp_empty", 32'(exp_rsp.size()), 32'd0);
        chk("sb_rd_empty", 32'(exp_rd.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
